// File: rtl/arm_instr_encoder.sv
// rtl/arm_instr_encoder.sv - packs field-level ARM instruction requests into 32-bit words with sequential addresses
module arm_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [3:0]        req_cond,
    input  logic [3:0]        req_cmd,
    input  logic              req_s,
    input  logic [3:0]        req_rn,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rm,
    input  logic [1:0]        req_sh,
    input  logic [4:0]        req_shamt,
    input  logic              req_useimm,
    input  logic [31:0]       req_imm32,
    input  logic              req_u,
    input  logic              req_b,
    input  logic              req_l,
    input  logic [11:0]       req_imm12,
    input  logic              req_link,
    input  logic [23:0]       req_imm24,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              enc_err
);

    typedef enum logic [1:0] {IDLE, SEARCH, EMIT, ERR} state_t;

    state_t      state;
    logic [3:0]  rot;
    logic [3:0]  l_cond;
    logic [3:0]  l_cmd;
    logic [3:0]  l_rn;
    logic [3:0]  l_rd;
    logic        l_s;
    logic [31:0] l_imm;

    logic        s_eff;
    logic [5:0]  rol_amt;
    logic [31:0] rol_v;

    // Compare-type commands (TST/TEQ/CMP/CMN) only exist to set flags.
    assign s_eff   = req_s || (req_cmd[3:2] == 2'b10);
    assign rol_amt = {1'b0, rot, 1'b0};
    assign rol_v   = (l_imm << rol_amt) | (l_imm >> (6'd32 - rol_amt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            enc_err   <= 1'b0;
            rot       <= '0;
            l_cond    <= '0;
            l_cmd     <= '0;
            l_rn      <= '0;
            l_rd      <= '0;
            l_s       <= 1'b0;
            l_imm     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_cond    <= req_cond;
                        l_cmd     <= req_cmd;
                        l_rn      <= req_rn;
                        l_rd      <= req_rd;
                        l_s       <= s_eff;
                        l_imm     <= req_imm32;
                        rot       <= '0;
                        req_ready <= 1'b0;
                        case (req_op)
                            2'b00: begin
                                if (req_useimm) begin
                                    state <= SEARCH;
                                end else begin
                                    out_instr <= {req_cond, 2'b00, 1'b0, req_cmd, s_eff, req_rn, req_rd,
                                                  req_shamt, req_sh, 1'b0, req_rm};
                                    out_valid <= 1'b1;
                                    state     <= EMIT;
                                end
                            end
                            2'b01: begin
                                out_instr <= {req_cond, 2'b01, 1'b0, 1'b1, req_u, req_b, 1'b0, req_l,
                                              req_rn, req_rd, req_imm12};
                                out_valid <= 1'b1;
                                state     <= EMIT;
                            end
                            2'b10: begin
                                out_instr <= {req_cond, 3'b101, req_link, req_imm24};
                                out_valid <= 1'b1;
                                state     <= EMIT;
                            end
                            default: begin
                                enc_err <= 1'b1;
                                state   <= ERR;
                            end
                        endcase
                    end
                end
                SEARCH: begin
                    // Rotations are tried in increasing order so the smallest legal one wins.
                    if (rol_v[31:8] == 24'd0) begin
                        out_instr <= {l_cond, 2'b00, 1'b1, l_cmd, l_s, l_rn, l_rd, rot, rol_v[7:0]};
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (rot == 4'd15) begin
                        enc_err <= 1'b1;
                        state   <= ERR;
                    end else begin
                        rot <= rot + 4'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_addr  <= out_addr + ADDR_W'(4);
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ERR: begin
                    enc_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/arm_instr_encoder.md
# arm_instr_encoder

Sequential ARM instruction encoder: the write-side counterpart of the core's instruction decoder. It accepts field-level instruction requests (data-processing, LDR/STR, B/BL) from the program loader or a test generator, packs them into 32-bit ARM machine words, and emits them with a sequential byte address for instruction memory. For data-processing immediates it iteratively searches for a legal 8-bit/4-bit-rotate encoding of a 32-bit constant, and flags constants it cannot encode.

## Interface
- ADDR_W, 32, width of emitted address
- BASE_ADDR, 0, address of first emitted word after reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept a request
- req_op  in  2  00 data-processing, 01 memory, 10 branch, 11 illegal
- req_cond  in  4  condition field
- req_cmd  in  4  DP command (Funct[4:1] encoding)
- req_s  in  1  DP set-flags
- req_rn, req_rd, req_rm  in  4 each  register numbers
- req_sh  in  2  shift type (00 LSL, 01 LSR, 10 ASR, 11 ROR)
- req_shamt  in  5  shift amount
- req_useimm  in  1  DP uses immediate operand
- req_imm32  in  32  DP constant to encode
- req_u, req_b, req_l  in  1 each  memory add-offset, byte, load
- req_imm12  in  12  memory offset
- req_link  in  1  branch with link
- req_imm24  in  24  branch word offset
- out_valid  out  1  instruction word available
- out_ready  in  1  downstream accepts word
- out_instr  out  32  encoded word
- out_addr  out  ADDR_W  byte address of out_instr
- enc_err  out  1  one-cycle pulse: request rejected

## Operation
- States: IDLE, SEARCH, EMIT, ERR.
- IDLE: req_ready=1. On req_valid: latch all fields. DP with req_useimm -> SEARCH (rot=0). req_op=11 -> ERR. Otherwise build word -> EMIT.
- SEARCH: each cycle v = ROL(imm32, 2*rot). If v[31:8]==0: src2={rot,v[7:0]}, -> EMIT. Else if rot==15 -> ERR. Else rot++. First (smallest) rot wins.
- EMIT: out_valid=1; out_instr/out_addr stable until out_ready. On out_valid&&out_ready: addr+=4 (wraps mod 2^ADDR_W), -> IDLE.
- ERR: enc_err=1 for exactly one cycle, no word emitted, addr unchanged, -> IDLE.
- DP word: cond[31:28], 00, I[25]=useimm, cmd[24:21], S[20], Rn[19:16], Rd[15:12], src2[11:0]. Register src2 = {shamt, sh, 0, Rm}. S forced 1 when cmd is 1000–1011 (TST/TEQ/CMP/CMN).
- Memory word: cond, 01, I=0, P=1, U, B, W=0, L, Rn, Rd, imm12.
- Branch word: cond, 101, L=req_link, imm24.

## Timing
- Reset (async): state IDLE, req_ready=1, out_valid=0, out_instr=0, out_addr=BASE_ADDR, enc_err=0, rot=0.
- Non-search request: accepted at edge N, out_valid high from cycle N+1.
- Immediate found at rotation k: SEARCH lasts k+1 cycles, out_valid rises on the cycle after the matching SEARCH cycle.
- Unencodable immediate: 16 SEARCH cycles, then enc_err high for one cycle, req_ready high again on the next cycle.
- req_ready=0 in SEARCH, EMIT, ERR. No request is accepted in the same cycle as an output handshake.
- out_ready is ignored while out_valid=0. out_ready held high gives one word per request with no stall.
- Reset during SEARCH or EMIT: the pending word is dropped and the address returns to BASE_ADDR.

## Test plan
- ADD R1,R2,#0xFF (cond E, cmd 0100, useimm) -> out_instr 0xE28210FF at out_addr 0x0, 1 SEARCH cycle.
- MOV R0,#0xFF000000 (cmd 1101) -> 5 SEARCH cycles, 0xE3A004FF. Wrap case #0xF000000F -> src2 0x2FF.
- DP #0x00000101 -> 16 SEARCH cycles, single enc_err pulse, no out_valid, address unchanged; the next request is emitted at the same address.
- CMP R1,R2 with req_s=0 -> 0xE1510002. LDR R3,[R4,#8] -> 0xE5943008. STR same fields -> 0xE5843008. BL imm24=0x10 -> 0xEB000010. Back-to-back: addresses 0x0, 0x4, 0x8, 0xC.
- Backpressure: out_ready low for 3 cycles in EMIT -> out_instr/out_addr stable, req_ready=0, single handshake, address +4. ADDR_W=4 with BASE_ADDR=0xC: after 1 word, address wraps to 0x0.
- Assert reset mid-SEARCH -> all outputs at reset values immediately, next request emitted at BASE_ADDR.
